// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue: instruction prefetch FIFO with redirect (flush) support.     |
// | Optional same-cycle forwarding of a beat into an empty queue:             |
// | define FETCH_BYPASS_EN.                                                   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] RST_VEC,
  output logic [15:0] MAB,
  output logic        mem_rd,
  input  logic        mem_rdy,
  input  logic [15:0] MDB_in,
  input  logic        flush,
  input  logic [15:0] flush_pc,
  output logic [15:0] ir_out,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_pc, w_pc_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [AW-1:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
  logic [15:0]   r_data [DEPTH];
  logic [15:0]   r_addr [DEPTH];
  logic          w_beat, w_push, w_pop, w_bypass, w_has_head;

  always_comb begin
    w_has_head = (r_count != '0);
    mem_rd     = (r_state == S_FETCH) && (r_count < c_depth) && !flush;
    MAB        = r_pc;
    w_beat     = mem_rd && mem_rdy;
`ifdef FETCH_BYPASS_EN
    w_bypass   = w_beat && !w_has_head;
`else
    w_bypass   = 1'b0;
`endif
    w_pop      = w_has_head && ir_ready;
    // A forwarded word the pipeline takes immediately never enters storage
    w_push     = w_beat && !(w_bypass && ir_ready);

    ir_valid   = w_has_head || w_bypass;
    ir_out     = 16'h0000;
    ir_pc      = 16'h0000;
    if (w_has_head) begin
      ir_out = r_data[r_rptr];
      ir_pc  = r_addr[r_rptr];
    end else if (w_bypass) begin
      ir_out = MDB_in;
      ir_pc  = r_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_count_nxt = r_count;
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    case (r_state)
      S_LOAD: begin
        w_pc_nxt    = RST_VEC & 16'hFFFE;
        w_state_nxt = S_FETCH;
      end
      S_FETCH, S_FULL: begin
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        if (w_push) w_wptr_nxt = r_wptr + AW'(1);
        if (w_pop)  w_rptr_nxt = r_rptr + AW'(1);
        if (w_beat) w_pc_nxt = r_pc + 16'd2;
        w_state_nxt = (w_count_nxt == c_depth) ? S_FULL : S_FETCH;
      end
      default: w_state_nxt = S_LOAD;
    endcase
    // Redirect wins over everything, including the reset-vector load
    if (flush) begin
      w_count_nxt = '0;
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
      w_pc_nxt    = flush_pc & 16'hFFFE;
      w_state_nxt = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOAD;
      r_pc    <= 16'h0000;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_count <= w_count_nxt;
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
    end
  end

  // Storage is only observed through the count-gated head mux, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wptr] <= MDB_in;
      r_addr[r_wptr] <= r_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_queue: self-checking bench for fetch_queue (DEPTH = 4).          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rst_vec;
  logic [15:0] MAB;
  logic        mem_rd;
  logic        mem_rdy;
  logic [15:0] MDB_in;
  logic        flush;
  logic [15:0] flush_pc;
  logic [15:0] ir_out;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .RST_VEC  (rst_vec),
    .MAB      (MAB),
    .mem_rd   (mem_rd),
    .mem_rdy  (mem_rdy),
    .MDB_in   (MDB_in),
    .flush    (flush),
    .flush_pc (flush_pc),
    .ir_out   (ir_out),
    .ir_pc    (ir_pc),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the queue contents as a list of {word, address}
  typedef struct packed {
    logic [15:0] d;
    logic [15:0] a;
  } ent_t;

  ent_t        q[$];
  logic        m_load;
  logic [15:0] m_pc;
  logic        s_fl, s_ready, s_beat, s_byp;
  logic [15:0] s_data, s_fpc;

  task automatic model_reset();
    q.delete();
    m_load = 1'b1;
    m_pc   = 16'h0000;
  endtask

  // Drive one cycle of inputs (at negedge) and compare outputs with the model
  task automatic apply(input logic fl, input logic rdy, input logic rdyp,
                       input logic [15:0] data, input logic [15:0] fpc);
    logic        e_rd, e_v;
    logic [15:0] e_out, e_pc;
    flush = fl; mem_rdy = rdy; ir_ready = rdyp; MDB_in = data; flush_pc = fpc;
    #1;
    e_rd   = !m_load && (q.size() < DEPTH) && !fl;
    s_beat = e_rd && rdy;
    s_byp  = 1'b0;
`ifdef FETCH_BYPASS_EN
    s_byp  = s_beat && (q.size() == 0);
`endif
    e_v   = (q.size() != 0) || s_byp;
    e_out = 16'h0000;
    e_pc  = 16'h0000;
    if (q.size() != 0) begin
      e_out = q[0].d;
      e_pc  = q[0].a;
    end else if (s_byp) begin
      e_out = data;
      e_pc  = m_pc;
    end
    s_fl = fl; s_ready = rdyp; s_data = data; s_fpc = fpc;
    chk("mdl_mab", MAB, m_pc);
    chk("mdl_mem_rd", {15'b0, mem_rd}, {15'b0, e_rd});
    chk("mdl_ir_valid", {15'b0, ir_valid}, {15'b0, e_v});
    chk("mdl_ir_out", ir_out, e_out);
    chk("mdl_ir_pc", ir_pc, e_pc);
  endtask

  // Clock edge, then advance the model by the rules for that cycle
  task automatic advance();
    @(posedge clk);
    if (m_load) begin
      m_pc   = s_fl ? (s_fpc & 16'hFFFE) : (rst_vec & 16'hFFFE);
      m_load = 1'b0;
    end else if (s_fl) begin
      q.delete();
      m_pc = s_fpc & 16'hFFFE;
    end else begin
      if (q.size() != 0 && s_ready) void'(q.pop_front());
      if (s_beat && !(s_byp && s_ready)) q.push_back({s_data, m_pc});
      if (s_beat) m_pc = m_pc + 16'd2;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        fl, rdy, rdyp;
    logic [15:0] data, fpc, mab;
    logic        rd, v;
    logic [15:0] out, pc;
  } vec_t;

  vec_t tab[11];

  initial begin
    tab[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tab[1]  = '{1'b0, 1'b1, 1'b0, 16'h1111, 16'h0000, 16'hC000, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tab[2]  = '{1'b0, 1'b1, 1'b0, 16'h2222, 16'h0000, 16'hC002, 1'b1, 1'b1, 16'h1111, 16'hC000};
    tab[3]  = '{1'b0, 1'b1, 1'b0, 16'h3333, 16'h0000, 16'hC004, 1'b1, 1'b1, 16'h1111, 16'hC000};
    tab[4]  = '{1'b0, 1'b1, 1'b0, 16'h4444, 16'h0000, 16'hC006, 1'b1, 1'b1, 16'h1111, 16'hC000};
    tab[5]  = '{1'b0, 1'b1, 1'b1, 16'h5555, 16'h0000, 16'hC008, 1'b0, 1'b1, 16'h1111, 16'hC000};
    tab[6]  = '{1'b0, 1'b0, 1'b0, 16'h6666, 16'h0000, 16'hC008, 1'b1, 1'b1, 16'h2222, 16'hC002};
    tab[7]  = '{1'b0, 1'b0, 1'b0, 16'h7777, 16'h0000, 16'hC008, 1'b1, 1'b1, 16'h2222, 16'hC002};
    tab[8]  = '{1'b0, 1'b1, 1'b0, 16'h9999, 16'h0000, 16'hC008, 1'b1, 1'b1, 16'h2222, 16'hC002};
    tab[9]  = '{1'b1, 1'b1, 1'b1, 16'hAAAA, 16'hF123, 16'hC00A, 1'b0, 1'b1, 16'h2222, 16'hC002};
    tab[10] = '{1'b0, 1'b0, 1'b0, 16'hBBBB, 16'h0000, 16'hF122, 1'b1, 1'b0, 16'h0000, 16'h0000};
`ifdef FETCH_BYPASS_EN
    tab[1].v   = 1'b1;
    tab[1].out = 16'h1111;
    tab[1].pc  = 16'hC000;
`endif

    rst = 1'b0; rst_vec = 16'hC001;
    flush = 1'b0; flush_pc = 16'h0000; mem_rdy = 1'b1; MDB_in = 16'h0000; ir_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mab", MAB, 16'h0000);
    chk("rst_mem_rd", {15'b0, mem_rd}, 16'h0000);
    chk("rst_ir_valid", {15'b0, ir_valid}, 16'h0000);
    chk("rst_ir_out", ir_out, 16'h0000);
    chk("rst_ir_pc", ir_pc, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      apply(tab[i].fl, tab[i].rdy, tab[i].rdyp, tab[i].data, tab[i].fpc);
      chk($sformatf("tab%0d_mab", i), MAB, tab[i].mab);
      chk($sformatf("tab%0d_mem_rd", i), {15'b0, mem_rd}, {15'b0, tab[i].rd});
      chk($sformatf("tab%0d_ir_valid", i), {15'b0, ir_valid}, {15'b0, tab[i].v});
      chk($sformatf("tab%0d_ir_out", i), ir_out, tab[i].out);
      chk($sformatf("tab%0d_ir_pc", i), ir_pc, tab[i].pc);
      advance();
    end

    // Address wrap at the top of memory
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF);
    advance();
    apply(1'b0, 1'b1, 1'b0, 16'hABCD, 16'h0000);
    chk("wrap_mab_before", MAB, 16'hFFFE);
    advance();
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("wrap_mab_after", MAB, 16'h0000);
    chk("wrap_ir_pc", ir_pc, 16'hFFFE);
    chk("wrap_ir_out", ir_out, 16'hABCD);
    advance();

    // Flush during the reset-vector load cycle
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    apply(1'b1, 1'b1, 1'b0, 16'h0000, 16'h1235);
    chk("loadflush_mem_rd", {15'b0, mem_rd}, 16'h0000);
    advance();
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("loadflush_mab", MAB, 16'h1234);
    chk("loadflush_mem_rd2", {15'b0, mem_rd}, 16'h0001);
    // Asynchronous reset in the middle of a wait state
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_mem_rd", {15'b0, mem_rd}, 16'h0000);
    chk("midrst_mab", MAB, 16'h0000);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

`ifdef FETCH_BYPASS_EN
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    advance();
    apply(1'b0, 1'b1, 1'b1, 16'h4031, 16'h0000);
    chk("byp_ir_valid", {15'b0, ir_valid}, 16'h0001);
    chk("byp_ir_out", ir_out, 16'h4031);
    advance();
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("byp_empty_after", {15'b0, ir_valid}, 16'h0000);
    advance();
`endif

    for (int i = 0; i < 3000; i++) begin
      apply(($urandom % 16) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
            16'($urandom), 16'($urandom));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue depth in 16-bit words (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port RST_VEC  input  16  reset vector; first fetch address after reset.
REQ-005 SHALL have port MAB  output  16  memory address bus; current fetch PC.
REQ-006 SHALL have port mem_rd  output  1  fetch read request.
REQ-007 SHALL have port mem_rdy  input  1  memory completes read this cycle; MDB_in valid.
REQ-008 SHALL have port MDB_in  input  16  memory read data.
REQ-009 SHALL have port flush  input  1  redirect request (branch/interrupt).
REQ-010 SHALL have port flush_pc  input  16  redirect target.
REQ-011 SHALL have port ir_out  output  16  head instruction word to pipeline.
REQ-012 SHALL have port ir_pc  output  16  address of ir_out word.
REQ-013 SHALL have port ir_valid  output  1  ir_out/ir_pc valid.
REQ-014 SHALL have port ir_ready  input  1  pipeline accepts head word.

Function
REQ-015 SHALL implement states LOAD, FETCH, FULL; reset enters LOAD.
REQ-016 LOAD SHALL last exactly one cycle: PC <= RST_VEC & 16'hFFFE, next state FETCH.
REQ-017 mem_rd SHALL be 1 only in FETCH with count < DEPTH and flush = 0; MAB = PC at all times.
REQ-018 A beat SHALL occur when mem_rd && mem_rdy: push {MDB_in, PC}, PC <= PC + 2 (16-bit wrap, 16'hFFFE -> 16'h0000).
REQ-019 mem_rd && !mem_rdy SHALL hold MAB and mem_rd stable (wait state), unlimited length.
REQ-020 A pop SHALL occur when ir_valid && ir_ready; head entry removed.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, preserving FIFO order.
REQ-022 FETCH -> FULL when count reaches DEPTH; FULL -> FETCH on the cycle after a pop.
REQ-023 ir_valid SHALL equal (count != 0); ir_out/ir_pc SHALL come from the head register (one-cycle beat-to-valid latency).
REQ-024 flush SHALL have priority over push/pop: count <= 0, PC <= flush_pc & 16'hFFFE, state <= FETCH, any beat that cycle discarded, no pop counted.
REQ-025 flush asserted in LOAD SHALL override the RST_VEC load.
REQ-026 Push with count == DEPTH SHALL be impossible by construction (mem_rd low).

Reset
REQ-027 rst low SHALL asynchronously set: state LOAD, PC 16'h0000, count 0, read/write pointers 0.
REQ-028 During reset: MAB 16'h0000, mem_rd 0, ir_valid 0, ir_out 16'h0000, ir_pc 16'h0000.
REQ-029 Reset mid-wait-state SHALL drop mem_rd immediately; the pending beat is abandoned.
REQ-030 Reset deassertion SHALL be honoured at the next rising edge (LOAD cycle).

Configuration
REQ-031 Macro FETCH_BYPASS_EN, when defined, SHALL forward a beat with count == 0 directly: ir_valid = 1, ir_out = MDB_in, ir_pc = PC in the same cycle; if ir_ready the word is not stored.
REQ-032 With FETCH_BYPASS_EN defined and ir_ready = 0, the bypassed beat SHALL be pushed normally.
REQ-033 Without FETCH_BYPASS_EN, behaviour SHALL be exactly REQ-023 (registered output only).

Verification
REQ-034 RST_VEC=16'hC001, rst released, mem_rdy=1, ir_ready=1 -> LOAD one cycle, then MAB 16'hC000, 16'hC002, ... ; ir_pc sequence 16'hC000, 16'hC002.
REQ-035 ir_ready=0, mem_rdy=1, DEPTH=4 -> exactly 4 beats, mem_rd low, state FULL; one pop -> mem_rd high the following cycle.
REQ-036 mem_rdy held 0 for 3 cycles at MAB 16'hC004 -> MAB/mem_rd stable 3 cycles, single push on 4th.
REQ-037 Queue holding 3 words, flush=1 with flush_pc=16'hF123 and concurrent beat -> next cycle ir_valid 0, MAB 16'hF122, beat discarded.
REQ-038 PC=16'hFFFE, beat -> ir_pc 16'hFFFE, next MAB 16'h0000.
REQ-039 FETCH_BYPASS_EN defined, empty queue, ir_ready=1, MDB_in=16'h4031 -> ir_valid and ir_out=16'h4031 same cycle, count stays 0.
